// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight register writers.
// Raises a combinational stall for not-yet-available results and produces
// registered A/B forward selects for the instruction entering EX.
// Optional feature macro: HAZARD_FWD_EN (defined = latency-aware forwarding;
// undefined = no forwarding, consumers wait until the producer reaches WB).
module hazard_scoreboard #(
  parameter int RAWIDTH = 5,
  parameter int DEPTH   = 3,
  parameter int LWIDTH  = 2,
  localparam int SWIDTH = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RAWIDTH-1:0] id_rs1,
  input  logic [RAWIDTH-1:0] id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [RAWIDTH-1:0] id_rd,
  input  logic               id_rd_we,
  input  logic [LWIDTH-1:0]  id_lat,
  input  logic               ex_flush,
  output logic               stall,
  output logic [SWIDTH-1:0]  fwd_a_sel,
  output logic [SWIDTH-1:0]  fwd_b_sel
);

  // Scoreboard: index k is pipeline stage k after ID (1 = EX ... DEPTH = WB).
  logic [DEPTH:1]     v_r;
  logic [RAWIDTH-1:0] rd_r [1:DEPTH];

  // Youngest matching producer stage per source (0 = none).
  logic [SWIDTH-1:0]  win_a_s;
  logic [SWIDTH-1:0]  win_b_s;
  logic               hazard_s;
  logic               stall_s;
  logic               load_s;

  // Priority search: scan oldest to youngest so the lowest stage is kept last.
  always_comb begin
    win_a_s = {SWIDTH{1'b0}};
    win_b_s = {SWIDTH{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      if (v_r[k] && (rd_r[k] != {RAWIDTH{1'b0}}) && id_rs1_used && (rd_r[k] == id_rs1)) begin
        win_a_s = SWIDTH'(k);
      end else begin
        win_a_s = win_a_s;
      end
      if (v_r[k] && (rd_r[k] != {RAWIDTH{1'b0}}) && id_rs2_used && (rd_r[k] == id_rs2)) begin
        win_b_s = SWIDTH'(k);
      end else begin
        win_b_s = win_b_s;
      end
    end
  end

`ifdef HAZARD_FWD_EN
  logic [LWIDTH-1:0] lat_r [1:DEPTH];
  logic [LWIDTH-1:0] lat_clamp_s;
  logic              early_a_s;
  logic              early_b_s;
  logic [SWIDTH-1:0] fwd_a_nxt_s;
  logic [SWIDTH-1:0] fwd_b_nxt_s;
  logic [SWIDTH-1:0] fwd_a_r;
  logic [SWIDTH-1:0] fwd_b_r;

  // Clamp issue latency into the legal window 1..DEPTH-1.
  always_comb begin
    lat_clamp_s = id_lat;
    if (id_lat == {LWIDTH{1'b0}}) begin
      lat_clamp_s = LWIDTH'(1);
    end else if (int'(id_lat) >= DEPTH) begin
      lat_clamp_s = LWIDTH'(DEPTH - 1);
    end else begin
      lat_clamp_s = id_lat;
    end
  end

  // A winning producer is "early" when it has not yet reached its result stage.
  always_comb begin
    early_a_s = 1'b0;
    early_b_s = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (win_a_s == SWIDTH'(k)) begin
        early_a_s = (k < int'(lat_r[k]));
      end else begin
        early_a_s = early_a_s;
      end
      if (win_b_s == SWIDTH'(k)) begin
        early_b_s = (k < int'(lat_r[k]));
      end else begin
        early_b_s = early_b_s;
      end
    end
  end

  // Hazard only when the youngest match cannot be forwarded yet.
  always_comb begin
    hazard_s = early_a_s | early_b_s;
  end

  // Next forward selects: producer moves to k+1 when consumer enters EX;
  // a producer already in WB is served by the register file.
  always_comb begin
    fwd_a_nxt_s = {SWIDTH{1'b0}};
    fwd_b_nxt_s = {SWIDTH{1'b0}};
    if (id_valid && !stall_s && !ex_flush) begin
      if ((win_a_s != {SWIDTH{1'b0}}) && (win_a_s != SWIDTH'(DEPTH))) begin
        fwd_a_nxt_s = win_a_s + SWIDTH'(1);
      end else begin
        fwd_a_nxt_s = {SWIDTH{1'b0}};
      end
      if ((win_b_s != {SWIDTH{1'b0}}) && (win_b_s != SWIDTH'(DEPTH))) begin
        fwd_b_nxt_s = win_b_s + SWIDTH'(1);
      end else begin
        fwd_b_nxt_s = {SWIDTH{1'b0}};
      end
    end else begin
      fwd_a_nxt_s = {SWIDTH{1'b0}};
      fwd_b_nxt_s = {SWIDTH{1'b0}};
    end
  end

  // Forward select registers, valid during the consumer's EX cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_r <= {SWIDTH{1'b0}};
      fwd_b_r <= {SWIDTH{1'b0}};
    end else begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end
  end

  // Latency field travels alongside the scoreboard entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        lat_r[k] <= {LWIDTH{1'b0}};
      end
    end else begin
      lat_r[1] <= lat_clamp_s;
      for (int k = 2; k <= DEPTH; k++) begin
        lat_r[k] <= lat_r[k-1];
      end
    end
  end

  assign fwd_a_sel = fwd_a_r;
  assign fwd_b_sel = fwd_b_r;
`else
  logic unused_lat_s;

  // Without forwarding, any match short of WB must wait.
  always_comb begin
    hazard_s = ((win_a_s != {SWIDTH{1'b0}}) && (win_a_s != SWIDTH'(DEPTH))) ||
               ((win_b_s != {SWIDTH{1'b0}}) && (win_b_s != SWIDTH'(DEPTH)));
  end

  assign unused_lat_s = ^id_lat;
  assign fwd_a_sel    = {SWIDTH{1'b0}};
  assign fwd_b_sel    = {SWIDTH{1'b0}};
`endif

  // Stall and entry-1 load decision; a flush discards the ID instruction.
  always_comb begin
    stall_s = id_valid && !ex_flush && hazard_s;
    load_s  = id_valid && id_rd_we && !stall_s && !ex_flush;
  end

  // Scoreboard shift: entry 1 takes ID or a bubble, older entries always advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r <= {DEPTH{1'b0}};
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= {RAWIDTH{1'b0}};
      end
    end else begin
      v_r[1]  <= load_s;
      rd_r[1] <= id_rd;
      for (int k = 2; k <= DEPTH; k++) begin
        v_r[k]  <= v_r[k-1];
        rd_r[k] <= rd_r[k-1];
      end
    end
  end

  assign stall = stall_s;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised hazard-detection and forwarding-control unit for the pipelined RISC-V core. It generalises the fixed EX/MEM/WB forwarding to a configurable pipeline depth and per-instruction result latency, e.g. single-cycle ALU results versus loads.
- It tracks every in-flight register writer in a shift-register scoreboard and asserts a load-use style stall when needed.
- It produces registered forwarding selects for the instruction entering EX.
- It sits beside the controller and drives the PC/ID register load enables and the A/B forward muxes.

## Interface
- `RAWIDTH`, 5, register address width.
- `DEPTH`, 3, number of tracked stages after ID: stage 1 = EX … stage `DEPTH` = WB. Legal range 2..7.
- `LWIDTH`, 2, width of the result-latency field.
- `SWIDTH`, `$clog2(DEPTH+1)`, localparam, forward-select width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  RAWIDTH  source registers.
- `id_rs1_used`, `id_rs2_used`  in  1  source actually read.
- `id_rd`  in  RAWIDTH  destination register.
- `id_rd_we`  in  1  instruction writes `id_rd`.
- `id_lat`  in  LWIDTH  stage whose output holds the result (1 = ALU/EX, 2 = load/MEM).
- `ex_flush`  in  1  taken branch/jump resolved in EX this cycle.
- `stall`  out  1  combinational; hold PC and ID, insert bubble.
- `fwd_a_sel`, `fwd_b_sel`  out  SWIDTH  registered; 0 = register file, j = stage j result.

## Operation
- Scoreboard entry per stage k = 1..DEPTH holds {`v`, `rd`, `lat`}.
- An entry is a producer only if `v`=1 and `rd`≠0.
- `id_lat` is clamped on issue: 0 → 1, ≥`DEPTH` → `DEPTH`-1.
- Every cycle, entries shift k → k+1. Entry `DEPTH` is dropped.
- The register file must provide write-before-read for the WB write.
- Entry 1 load rule:
  - ID is loaded into entry 1 when `id_valid`, `id_rd_we`, `!stall` and `!ex_flush` all hold.
  - Otherwise entry 1 is loaded invalid (bubble).
- Match for source s: a producer at stage k with `rd`==s, where `id_rsN_used`=1.
  - The youngest match (lowest k) wins.
  - Older matches are ignored.
- `stall` = `id_valid` & !`ex_flush` & (winning match for rs1 or rs2 has k < `lat`).
- Forward select on the edge that loads EX: `fwd_x_sel` ← k+1 of the winning match.
  - It is 0 if there is no match.
  - It is 0 if the cycle stalls, flushes, or `id_valid`=0 (bubble).
- `ex_flush` suppresses `stall` in the same cycle; the ID instruction is discarded.
- Older entries (k ≥ 1) always advance; they are never flushed by this block.

## Timing
- Reset: all entries `v`=0, `fwd_a_sel`=`fwd_b_sel`=0, `stall`=0.
- Reset mid-operation clears the scoreboard immediately (asynchronous). Normal operation resumes on the first edge after `rst` rises.
- `stall` has zero-cycle latency from ID inputs.
- Forward selects have one-cycle latency: they are valid during the consumer's EX cycle.
- Load followed by a consumer: exactly one stall cycle, then `fwd_sel`=3.
- ALU followed by a consumer: no stall, `fwd_sel`=2.
- Producer already at stage `DEPTH` when the consumer is in ID: no forward; the register-file path is used.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_a_sel`/`fwd_b_sel` are tied to 0.
  - `stall` asserts while a matching producer sits at any stage k < `DEPTH`, regardless of `lat`.
  - The consumer waits until the producer reaches WB.

## Test plan
- `addi x5` (lat 1) in ID, next cycle consumer `rs1=x5` → `stall`=0; during the consumer's EX, `fwd_a_sel`=2.
- `lw x6` (lat 2), next cycle consumer `rs2=x6` → `stall`=1 for exactly one cycle, one bubble; then `fwd_b_sel`=3 in EX.
- Writers to x7 at stages 1 and 2, consumer `rs1=x7` → `fwd_a_sel`=2 (youngest wins), `stall`=0.
- Producer with `rd=x0`, or consumer with `id_rs1_used`=0 → `stall`=0, selects 0.
- `ex_flush`=1 while a load-use consumer is in ID → `stall`=0, bubble inserted, selects 0 next cycle.
  - Also: drop `rst` mid-stream → all outputs 0 immediately.
- Without `HAZARD_FWD_EN`, `DEPTH`=3, ALU producer then dependent consumer → `stall`=1 for two cycles, selects always 0.
